// File: rtl/conv1x1_sched_pkg.sv
// Shared definitions for the 1x1 convolution output-channel scheduler.
//   state_t    : scheduler FSM states
//   MAC_LAT    : edges from an issue cycle to its registered result
//   cnt_width  : counter width helper (clog2 with a minimum of 1)
package conv1x1_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int MAC_LAT = 2;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv1x1_mac_lane.sv
// Shared pipelined MAC lane: one output channel's dot product per issue.
//   Stage 1 registers the IN_CH signed products plus bias and tag.
//   Stage 2 (combinational on stage-1 registers) sums products and bias
//   in a wide accumulator, truncates to Datawidth and optionally applies
//   ReLU; the consumer registers o_result when o_valid is high.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_valid, i_tag    issue strobe and output-channel tag
//   i_pix, i_wgt      IN_CH packed samples / weights (channel i at i*Datawidth)
//   i_bias            bias for the issued channel
//   o_valid, o_tag    result strobe and its tag
//   o_result          truncated (and optionally clamped) result
module conv1x1_mac_lane #(
  parameter int Datawidth = 32,
  parameter int IN_CH     = 12,
  parameter int ReLU      = 0,
  parameter int TAG_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic [TAG_W-1:0]           i_tag,
  input  logic [IN_CH*Datawidth-1:0] i_pix,
  input  logic [IN_CH*Datawidth-1:0] i_wgt,
  input  logic [Datawidth-1:0]       i_bias,
  output logic                       o_valid,
  output logic [TAG_W-1:0]           o_tag,
  output logic [Datawidth-1:0]       o_result
);

  localparam int PW    = 2 * Datawidth;
  localparam int ACC_W = PW + $clog2(IN_CH + 1);

  logic signed [PW-1:0]    w_prod [IN_CH];
  logic signed [PW-1:0]    r_prod [IN_CH];
  logic [Datawidth-1:0]    r_bias;
  logic [TAG_W-1:0]        r_tag;
  logic                    r_valid;
  logic signed [ACC_W-1:0] w_acc;
  logic [Datawidth-1:0]    w_res;

  // Operands are sign-extended to full product width before multiplying.
  always_comb begin
    for (int unsigned i = 0; i < IN_CH; i++) begin
      w_prod[i] = $signed({{Datawidth{i_pix[i*Datawidth+Datawidth-1]}}, i_pix[i*Datawidth +: Datawidth]})
                * $signed({{Datawidth{i_wgt[i*Datawidth+Datawidth-1]}}, i_wgt[i*Datawidth +: Datawidth]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_bias  <= '0;
      for (int unsigned i = 0; i < IN_CH; i++) r_prod[i] <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_tag  <= i_tag;
        r_bias <= i_bias;
        for (int unsigned i = 0; i < IN_CH; i++) r_prod[i] <= w_prod[i];
      end
    end
  end

  always_comb begin
    w_acc = {{(ACC_W-Datawidth){r_bias[Datawidth-1]}}, r_bias};
    for (int unsigned i = 0; i < IN_CH; i++) begin
      w_acc = w_acc + {{(ACC_W-PW){r_prod[i][PW-1]}}, r_prod[i]};
    end
    // Low Datawidth bits only: wraps with no saturation.
    w_res = Datawidth'(w_acc);
    if (ReLU != 0 && w_res[Datawidth-1]) w_res = '0;
  end

  assign o_valid  = r_valid;
  assign o_tag    = r_tag;
  assign o_result = w_res;

endmodule

// File: rtl/conv1x1_oc_scheduler.sv
// Time-multiplexed 1x1 convolution: holds one pixel vector, issues one
// output channel per cycle to a shared MAC lane, gathers OUT_CH results
// into an output buffer and hands them downstream via valid/ready.
// Counts delivered pixels and pulses frame_done after the last of a frame.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     pixel input handshake, in_data IN_CH samples
//   out_valid/out_ready   result handshake, out_data OUT_CH results
//   frame_done            one-cycle pulse after a frame's last delivery
//   busy                  scheduler not idle
module conv1x1_oc_scheduler
  import conv1x1_sched_pkg::*;
#(
  parameter int IMG_Width  = 3,
  parameter int IMG_Height = 3,
  parameter int Datawidth  = 32,
  parameter int IN_CH      = 12,
  parameter int OUT_CH     = 4,
  parameter int ReLU       = 0,
  parameter logic [OUT_CH*IN_CH*Datawidth-1:0] WEIGHTS = {(OUT_CH*IN_CH){Datawidth'(1)}},
  parameter logic [OUT_CH*Datawidth-1:0]       BIASES  =
    {Datawidth'(4), Datawidth'(3), Datawidth'(2), Datawidth'(1)}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_CH*Datawidth-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_CH*Datawidth-1:0] out_data,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int NPIX = IMG_Width * IMG_Height;
  localparam int OC_W = cnt_width(OUT_CH);
  localparam int WT_W = cnt_width(MAC_LAT + 1);
  localparam int PC_W = cnt_width(NPIX);

  state_t                      r_state, w_state_nxt;
  logic [OC_W-1:0]             r_oc, w_oc_nxt;
  logic [WT_W-1:0]             r_wait, w_wait_nxt;
  logic [PC_W-1:0]             r_pcnt, w_pcnt_nxt;
  logic                        r_fdone, w_fdone_nxt;
  logic                        w_load, w_issue;
  logic [IN_CH*Datawidth-1:0]  r_pix;
  logic [OUT_CH*Datawidth-1:0] r_out;
  logic [IN_CH*Datawidth-1:0]  w_wgt;
  logic [Datawidth-1:0]        w_bias;
  logic                        w_mac_valid;
  logic [OC_W-1:0]             w_mac_tag;
  logic [Datawidth-1:0]        w_mac_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_oc    <= '0;
      r_wait  <= '0;
      r_pcnt  <= '0;
      r_fdone <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_oc    <= w_oc_nxt;
      r_wait  <= w_wait_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_fdone <= w_fdone_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_oc_nxt    = r_oc;
    w_wait_nxt  = r_wait;
    w_pcnt_nxt  = r_pcnt;
    w_fdone_nxt = 1'b0;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_oc_nxt    = '0;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_issue = 1'b1;
        if (r_oc == OC_W'(OUT_CH - 1)) begin
          w_oc_nxt    = '0;
          w_wait_nxt  = WT_W'(MAC_LAT);
          w_state_nxt = WAIT;
        end else begin
          w_oc_nxt = r_oc + 1'b1;
        end
      end
      WAIT: begin
        w_wait_nxt = r_wait - 1'b1;
        if (r_wait == WT_W'(1)) w_state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
          if (r_pcnt == PC_W'(NPIX - 1)) begin
            w_pcnt_nxt  = '0;
            w_fdone_nxt = 1'b1;
          end else begin
            w_pcnt_nxt = r_pcnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_pix <= '0;
    else if (w_load) r_pix <= in_data;
  end

  assign w_wgt  = WEIGHTS[r_oc*IN_CH*Datawidth +: IN_CH*Datawidth];
  assign w_bias = BIASES[r_oc*Datawidth +: Datawidth];

  conv1x1_mac_lane #(
    .Datawidth (Datawidth),
    .IN_CH     (IN_CH),
    .ReLU      (ReLU),
    .TAG_W     (OC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_issue),
    .i_tag    (r_oc),
    .i_pix    (r_pix),
    .i_wgt    (w_wgt),
    .i_bias   (w_bias),
    .o_valid  (w_mac_valid),
    .o_tag    (w_mac_tag),
    .o_result (w_mac_res)
  );

  // Write-back runs off the lane's valid, independent of the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_out <= '0;
    else if (w_mac_valid) r_out[w_mac_tag*Datawidth +: Datawidth] <= w_mac_res;
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == OUT);
  assign busy       = (r_state != IDLE);
  assign out_data   = r_out;
  assign frame_done = r_fdone;

endmodule

// File: tb/tb_conv1x1_oc_scheduler.sv
module tb_conv1x1_oc_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance (ReLU=0, Datawidth=32)
  logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [383:0] a_in_data = '0;
  logic [127:0] a_out_data;
  logic         a_frame_done, a_busy;

  // ReLU=1 instance
  logic         r_in_valid = 1'b0, r_in_ready, r_out_valid, r_out_ready = 1'b1;
  logic [383:0] r_in_data = '0;
  logic [127:0] r_out_data;
  logic         r_frame_done, r_busy;

  // Datawidth=8 instance, bias 1 on every filter
  logic         n_in_valid = 1'b0, n_in_ready, n_out_valid, n_out_ready = 1'b1;
  logic [95:0]  n_in_data = '0;
  logic [31:0]  n_out_data;
  logic         n_frame_done, n_busy;

  conv1x1_oc_scheduler dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .frame_done(a_frame_done), .busy(a_busy)
  );

  conv1x1_oc_scheduler #(.ReLU(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
    .frame_done(r_frame_done), .busy(r_busy)
  );

  conv1x1_oc_scheduler #(.Datawidth(8), .BIASES({4{8'd1}})) dut_n (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .frame_done(n_frame_done), .busy(n_busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({a_in_ready, a_out_valid, a_frame_done, a_busy} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl: got {in_ready,out_valid,frame_done,busy}=%b want 1000",
               {a_in_ready, a_out_valid, a_frame_done, a_busy});
    end
    total++;
    if (a_out_data !== 128'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", a_out_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [127:0] exp_d;
    int vmiss;
    exp_d = {32'd28, 32'd27, 32'd26, 32'd25};
    a_in_data   = {12{32'd2}};
    a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b1;
    @(posedge clk);  // acceptance edge E0
    #1;
    a_in_valid = 1'b0;
    total++;
    if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_accept: got in_ready=%b busy=%b want 0 1", a_in_ready, a_busy);
    end
    vmiss = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (a_out_valid !== (k >= 6)) vmiss++;
    end
    total++;
    if (vmiss != 0) begin
      bad++;
      $display("FAIL basic_latency: out_valid wrong on %0d of 6 cycles, want rise after E0+6", vmiss);
    end
    total++;
    if (a_out_data !== exp_d) begin
      bad++;
      $display("FAIL basic_data: got %h want %h", a_out_data, exp_d);
    end
    @(posedge clk);  // handshake
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_handshake: got out_valid=%b in_ready=%b want 0 1", a_out_valid, a_in_ready);
    end
    total++;
    if (a_out_data !== exp_d) begin
      bad++;
      $display("FAIL basic_retain: got %h want %h", a_out_data, exp_d);
    end
  endtask

  task automatic test_stall();
    logic [127:0] exp_d;
    int smiss;
    exp_d = {32'd70, 32'd69, 32'd68, 32'd67};
    for (int i = 0; i < 12; i++) a_in_data[i*32 +: 32] = i;
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    for (int k = 0; k < 20 && a_out_valid !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (a_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_timeout: out_valid=%b want 1 within 20 cycles", a_out_valid);
    end
    smiss = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_busy !== 1'b1 || a_out_data !== exp_d)
        smiss++;
    end
    total++;
    if (smiss != 0) begin
      bad++;
      $display("FAIL stall_hold: %0d of 5 stalled cycles wrong, data=%h want %h", smiss, a_out_data, exp_d);
    end
    @(negedge clk);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: got out_valid=%b in_ready=%b want 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_relu();
    logic [127:0] exp_a;
    exp_a = {32'hFFFF_FFE0, 32'hFFFF_FFDF, 32'hFFFF_FFDE, 32'hFFFF_FFDD};
    a_in_data   = {12{32'hFFFF_FFFD}};
    r_in_data   = {12{32'hFFFF_FFFD}};
    a_out_ready = 1'b1;
    r_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b1;
    r_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    r_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (a_out_valid !== 1'b1 || a_out_data !== exp_a) begin
      bad++;
      $display("FAIL relu_off: got valid=%b data=%h want 1 %h", a_out_valid, a_out_data, exp_a);
    end
    total++;
    if (r_out_valid !== 1'b1 || r_out_data !== 128'h0) begin
      bad++;
      $display("FAIL relu_on: got valid=%b data=%h want 1 0", r_out_valid, r_out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_narrow();
    n_in_data   = {12{8'd100}};
    n_out_ready = 1'b1;
    @(negedge clk);
    n_in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (n_out_valid !== 1'b1 || n_out_data !== {4{8'hB1}}) begin
      bad++;
      $display("FAIL narrow_wrap: got valid=%b data=%h want 1 b1b1b1b1", n_out_valid, n_out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int vseen;
    a_in_data   = {12{32'd5}};
    a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    @(posedge clk);  // now in ISSUE
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({a_in_ready, a_out_valid, a_busy} !== 3'b100 || a_out_data !== 128'h0) begin
      bad++;
      $display("FAIL midrst_values: got {in_ready,out_valid,busy}=%b data=%h want 100 0",
               {a_in_ready, a_out_valid, a_busy}, a_out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    vseen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (a_out_valid === 1'b1 || a_out_data !== 128'h0) vseen++;
    end
    total++;
    if (vseen != 0) begin
      bad++;
      $display("FAIL midrst_discard: %0d cycles showed out_valid or write-back, want 0", vseen);
    end
    a_in_data = {12{32'd2}};
    @(negedge clk);
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (a_out_valid !== 1'b1 || a_out_data !== {32'd28, 32'd27, 32'd26, 32'd25}) begin
      bad++;
      $display("FAIL midrst_next: got valid=%b data=%h want 1 0000001c0000001b0000001a00000019",
               a_out_valid, a_out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int hs, pulses, last_hs, fd_miss, gap_miss;
    logic prev_ov, is_hs, exp_fd;
    do_reset();
    a_in_data   = {12{32'd2}};
    a_out_ready = 1'b1;
    hs = 0; pulses = 0; last_hs = 0; fd_miss = 0; gap_miss = 0;
    prev_ov = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b1;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(posedge clk);
      #1;
      is_hs = prev_ov;
      if (is_hs) begin
        hs++;
        if (hs > 1 && cyc - last_hs != 8) gap_miss++;
        last_hs = cyc;
      end
      exp_fd = is_hs && (hs == 9 || hs == 18);
      if (a_frame_done === 1'b1) pulses++;
      total++;
      if (a_frame_done !== exp_fd) begin
        bad++;
        fd_miss++;
        $display("FAIL frame_done_cyc%0d: got %b want %b (handshakes=%0d)", cyc, a_frame_done, exp_fd, hs);
      end
      prev_ov = a_out_valid;
    end
    a_in_valid = 1'b0;
    total++;
    if (hs != 18 || pulses != 2) begin
      bad++;
      $display("FAIL frame_count: got handshakes=%0d pulses=%0d want 18 2", hs, pulses);
    end
    total++;
    if (gap_miss != 0) begin
      bad++;
      $display("FAIL throughput: %0d handshake gaps differ from 8 cycles, want 0", gap_miss);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_relu();
    test_narrow();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv1x1_oc_scheduler.md
# conv1x1_oc_scheduler

Time-multiplexed scheduler for a 1x1 convolution layer with IN_CH input channels and OUT_CH output channels. It uses a single shared pipelined MAC lane instead of one MAC per output channel. Each accepted pixel vector is held while the block steps through the output channels and selects each channel's weights and bias. It collects the OUT_CH results into an output buffer and presents them through a valid/ready handshake. It sits between the feature-map streamer and the next layer's input, and counts pixels to flag end-of-frame.

## Interface
- IMG_Width, 3, pixels per row
- IMG_Height, 3, rows per frame
- Datawidth, 32, signed two's-complement sample width
- IN_CH, 12, input channels per pixel
- OUT_CH, 4, output channels (filters)
- ReLU, 0, 1 = clamp negative results to 0
- WEIGHTS, all 1, packed OUT_CH*IN_CH*Datawidth; filter o, channel i at slice [(o*IN_CH+i)*Datawidth +: Datawidth]
- BIASES, {4,3,2,1}, packed OUT_CH*Datawidth; filter o at slice [o*Datawidth +: Datawidth]

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a pixel
- in_data  in  IN_CH*Datawidth  channel i at [i*Datawidth +: Datawidth]
- out_valid  out  1  out_data holds a complete pixel
- out_ready  in  1  downstream accepts
- out_data  out  OUT_CH*Datawidth  filter o result at [o*Datawidth +: Datawidth]
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is delivered
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE
  - in_ready=1, combinational from state.
  - On in_valid&&in_ready, latch in_data into the pixel register, set oc=0 and go to ISSUE.
- ISSUE
  - One issue per cycle to the MAC lane: pixel register, the WEIGHTS slice for filter oc, BIASES[oc], and a tag oc.
  - oc increments each cycle. After issuing oc=OUT_CH-1, go to WAIT with the wait counter set to MAC_LAT.
- WAIT
  - Decrement the wait counter each cycle. When it reaches 0, go to OUT.
- MAC result write-back
  - Each MAC result is written to out_data slice[tag] on the cycle the lane's result-valid is high.
  - Write-back is independent of the FSM.
- OUT
  - out_valid=1 and out_data is stable.
  - On out_ready, go to IDLE and increment the pixel counter.
  - When the counter reaches IMG_Width*IMG_Height-1 at that handshake: wrap it to 0 and pulse frame_done on the next cycle.
- MAC arithmetic
  - Form signed products of full 2*Datawidth width and sum them with bias in a 2*Datawidth+clog2(IN_CH+1) accumulator.
  - The result is the low Datawidth bits, wrapping with no saturation.
  - If ReLU=1, a result whose truncated value is negative becomes 0.
- in_ready=0 in ISSUE, WAIT and OUT; no new pixel is accepted until the current one is delivered.
- out_data retains its last value after the handshake until overwritten by a write-back.

## Timing
- MAC_LAT=2: a result is registered 2 edges after its issue cycle.
- Take acceptance edge E0 as the reference:
  - issues occur in cycles E0..E0+OUT_CH-1;
  - the last write-back is at edge E0+OUT_CH+1;
  - out_valid rises after edge E0+OUT_CH+2 (defaults: 6 cycles after acceptance).
- Throughput: with out_ready held high, one pixel per OUT_CH+4 cycles (defaults: 8).
- Reset values (asynchronous on rst):
  - state IDLE, oc 0, wait counter 0, pixel counter 0;
  - out_valid 0, out_data 0, frame_done 0, busy 0;
  - MAC pipeline valid bits 0, and in_ready 1 (state is IDLE).
- Reset mid-operation: the partially processed pixel is discarded and no out_valid follows. The first pixel after reset is pixel 0 of a new frame.
- in_valid during ISSUE, WAIT or OUT is ignored; the source must hold it.
- out_ready while out_valid=0 has no effect.
- frame_done is never high for two consecutive cycles.

## Structure
- Package conv1x1_sched_pkg contains:
  - the state enum (IDLE, ISSUE, WAIT, OUT);
  - localparam MAC_LAT=2;
  - a function for counter widths (clog2 with a minimum of 1).
- Sub-module conv1x1_mac_lane contains:
  - a 2-stage pipeline, with products in stage 1 and adder tree + bias + ReLU in stage 2;
  - a valid and tag carried alongside the data;
  - parameters Datawidth, IN_CH, ReLU.
- The top module holds the FSM, counters, pixel register, weight/bias muxing and output buffer.

## Test plan
- Defaults, all channels = 2, out_ready=1 → out_data = {28,27,26,25} (filter 0 = 25); out_valid rises 6 cycles after acceptance.
- out_ready low for 5 cycles while out_valid=1 → out_data stable, in_ready=0, busy=1; delivery on the first out_ready cycle.
- Stream 9 pixels back-to-back at 3x3 → frame_done pulses exactly once, 1 cycle after the 9th handshake; a 10th pixel starts a new count (pulse after the 18th).
- ReLU=1, all channels = -3 → filters give -36+bias → all four outputs 0. With ReLU=0 → {-32,-33,-34,-35}.
- Datawidth=8, all channels = 100, weights 1, bias 1 → 1201 wraps to 0xB1, which is -79 signed.
- Assert rst during ISSUE → outputs return to reset values immediately, no out_valid appears, and the next pixel is processed correctly.
